// File: rtl/uart_rx_fifo_regs.sv
// Receive buffer and receive-side status/interrupt logic.
// The deserialiser pushes characters together with their {BI,FE,PE} flags,
// and the CPU pops them. In FIFO mode the buffer holds DEPTH entries;
// otherwise it behaves as a single holding register. LSR and IIR are
// registered from the stored state.
module uart_rx_fifo_regs #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int TO_CYCLES = 640
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WR,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [2:0]        ErrIn,
  input  logic              RD,
  input  logic              LSR_RD,
  input  logic [7:0]        FCR,
  input  logic [7:0]        IER,
  output logic [DATA_W-1:0] DataOut,
  output logic [7:0]        LSR,
  output logic [7:0]        IIR,
  output logic [AW:0]       RxLevel,
  output logic              INTR
);

  localparam int EW = DATA_W + 3;
  localparam int TW = $clog2(TO_CYCLES + 1);

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [DEPTH-1:0] err_vec;
  logic             oe;
  logic             fcr0_q;
  logic [TW-1:0]    to_cnt;

  logic          fifo_en, fcr_edge, flush;
  logic [AW:0]   cap, trig;
  logic          full, do_push, do_pop, overrun;
  logic [EW-1:0] head;
  logic [2:0]    head_err;
  logic          cto;
  logic [7:0]    lsr_d, iir_d;
  logic          unused_bits;

  assign unused_bits = ^{IER[7:3], IER[1], FCR[5:2]};

  assign fifo_en  = FCR[0];
  assign fcr_edge = FCR[0] ^ fcr0_q;
  assign flush    = fcr_edge | FCR[1];
  assign cap      = fifo_en ? (AW+1)'(DEPTH) : (AW+1)'(1);
  assign full     = (count >= cap);
  assign do_pop   = RD && (count != '0) && !flush;
  assign do_push  = WR && !flush && (!full || do_pop);
  assign overrun  = WR && !flush && full && !do_pop;
  assign head     = mem[rd_ptr];
  assign head_err = (count != '0) ? head[EW-1:DATA_W] : 3'b000;
  // The down-counter reaching zero is the "idle for TO_CYCLES" terminal count.
  assign cto      = fifo_en && (to_cnt == '0);
  assign RxLevel  = count;
  assign INTR     = ~IIR[0];

  // Trigger level selection; a single entry is enough outside FIFO mode.
  always_comb begin
    trig = (AW+1)'(1);
    if (fifo_en) begin
      case (FCR[7:6])
        2'b00:   trig = (AW+1)'(1);
        2'b01:   trig = (AW+1)'(DEPTH / 4);
        2'b10:   trig = (AW+1)'(DEPTH / 2);
        default: trig = (AW+1)'(DEPTH - 2);
      endcase
    end
  end

  // Character storage; contents are don't-care until marked valid by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {ErrIn, DataIn};
  end

  // Pointers, level, per-entry error marks, popped data and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_vec <= '0;
      DataOut <= '0;
      oe      <= 1'b0;
      fcr0_q  <= 1'b0;
    end else begin
      fcr0_q <= FCR[0];
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        err_vec <= '0;
      end else begin
        if (do_pop) begin
          rd_ptr          <= rd_ptr + 1'b1;
          DataOut         <= head[DATA_W-1:0];
          err_vec[rd_ptr] <= 1'b0;
        end
        // On a full push+pop the pointers coincide, so the push mark must win.
        if (do_push) begin
          wr_ptr          <= wr_ptr + 1'b1;
          err_vec[wr_ptr] <= |ErrIn;
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (fcr_edge)     oe <= 1'b0;
      else if (overrun) oe <= 1'b1;
      else if (LSR_RD)  oe <= 1'b0;
    end
  end

  // Idle timer: reloads on any bus/deserialiser activity or when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            to_cnt <= TW'(TO_CYCLES);
    else if (WR || RD || (count == '0))    to_cnt <= TW'(TO_CYCLES);
    else if (to_cnt != '0)                 to_cnt <= to_cnt - 1'b1;
  end

  // Next LSR and IIR values; IIR follows RLS > RDA > CTO priority.
  always_comb begin
    lsr_d = {fifo_en && (|err_vec), 2'b00, head_err, oe, count != '0};
    iir_d = {fifo_en ? 2'b11 : 2'b00, 2'b00, 4'b0001};
    if (IER[2] && (oe || (head_err != 3'b000)))  iir_d[3:0] = 4'b0110;
    else if (IER[0] && (count >= trig))          iir_d[3:0] = 4'b0100;
    else if (IER[0] && cto)                      iir_d[3:0] = 4'b1100;
  end

  // Status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      LSR <= 8'h00;
      IIR <= 8'h01;
    end else begin
      LSR <= lsr_d;
      IIR <= iir_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_regs.sv
// Directed bench for uart_rx_fifo_regs with a character scoreboard.
module tb_uart_rx_fifo_regs;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int TO_CYCLES = 640;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              WR = 1'b0;
  logic [DATA_W-1:0] DataIn = '0;
  logic [2:0]        ErrIn = '0;
  logic              RD = 1'b0;
  logic              LSR_RD = 1'b0;
  logic [7:0]        FCR = 8'h00;
  logic [7:0]        IER = 8'h00;
  logic [DATA_W-1:0] DataOut;
  logic [7:0]        LSR;
  logic [7:0]        IIR;
  logic [AW:0]       RxLevel;
  logic              INTR;

  int errors = 0;
  int checks = 0;
  int m_cap  = 1;
  logic [7:0] sb [$];
  logic [7:0] last_out = 8'h00;

  uart_rx_fifo_regs #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .TO_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .reset(reset), .WR(WR), .DataIn(DataIn), .ErrIn(ErrIn),
    .RD(RD), .LSR_RD(LSR_RD), .FCR(FCR), .IER(IER),
    .DataOut(DataOut), .LSR(LSR), .IIR(IIR), .RxLevel(RxLevel), .INTR(INTR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] e);
    @(negedge clk);
    WR = 1'b1; DataIn = d; ErrIn = e;
    @(negedge clk);
    WR = 1'b0; ErrIn = 3'b000;
    if (sb.size() < m_cap) sb.push_back(d);
  endtask

  task automatic pop();
    logic [7:0] exp;
    @(negedge clk);
    RD = 1'b1;
    @(negedge clk);
    RD = 1'b0;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk("pop_data", {24'h0, DataOut}, {24'h0, exp});
      last_out = exp;
    end else begin
      chk("rd_empty_hold", {24'h0, DataOut}, {24'h0, last_out});
    end
  endtask

  task automatic push_pop(input logic [7:0] d);
    logic [7:0] exp;
    @(negedge clk);
    WR = 1'b1; RD = 1'b1; DataIn = d; ErrIn = 3'b000;
    @(negedge clk);
    WR = 1'b0; RD = 1'b0;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk("pushpop_data", {24'h0, DataOut}, {24'h0, exp});
      last_out = exp;
    end
    sb.push_back(d);
  endtask

  task automatic lsr_read();
    @(negedge clk);
    LSR_RD = 1'b1;
    @(negedge clk);
    LSR_RD = 1'b0;
  endtask

  initial begin
    // Reset values
    idle(2);
    chk("rst_lsr", {24'h0, LSR}, 32'h00);
    chk("rst_iir", {24'h0, IIR}, 32'h01);
    chk("rst_level", {27'h0, RxLevel}, 32'h0);
    chk("rst_dout", {24'h0, DataOut}, 32'h0);
    chk("rst_intr", {31'h0, INTR}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Holding-register mode: second char overruns
    m_cap = 1;
    push(8'hA5, 3'b000);
    push(8'h3C, 3'b000);
    idle(2);
    chk("nf_lsr", {24'h0, LSR}, 32'h03);
    chk("nf_level", {27'h0, RxLevel}, 32'h1);
    pop();
    lsr_read();
    idle(2);
    chk("nf_lsr_clr", {24'h0, LSR}, 32'h00);

    // FIFO mode, trigger select 10 -> 8 entries
    @(negedge clk);
    FCR = 8'h81; IER = 8'h01;
    sb.delete(); m_cap = DEPTH;
    idle(2);
    chk("f_level0", {27'h0, RxLevel}, 32'h0);
    chk("f_iir_idle", {24'h0, IIR}, 32'hC1);
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i), 3'b000);
    idle(2);
    chk("f_level8", {27'h0, RxLevel}, 32'h8);
    chk("f_iir_rda", {24'h0, IIR}, 32'hC4);
    chk("f_intr", {31'h0, INTR}, 32'h1);
    pop();
    idle(2);
    chk("f_iir_below", {24'h0, IIR}, 32'hC1);

    // Fill to 16, simultaneous push+pop when full, then overrun
    for (int i = 0; i < 9; i++) push(8'(8'h40 + i), 3'b000);
    idle(1);
    chk("f_level16", {27'h0, RxLevel}, 32'h10);
    push_pop(8'hE0);
    idle(2);
    chk("f_full_pp_level", {27'h0, RxLevel}, 32'h10);
    chk("f_full_pp_oe", {31'h0, LSR[1]}, 32'h0);
    push(8'hE1, 3'b000);
    idle(2);
    chk("f_ovr_oe", {31'h0, LSR[1]}, 32'h1);
    chk("f_ovr_level", {27'h0, RxLevel}, 32'h10);
    lsr_read();
    idle(2);
    chk("f_oe_clr", {31'h0, LSR[1]}, 32'h0);
    for (int i = 0; i < DEPTH; i++) pop();
    pop();
    idle(2);
    chk("f_drained_lsr", {24'h0, LSR}, 32'h00);

    // Error char at head with trigger 1: RLS outranks RDA
    @(negedge clk);
    FCR = 8'h01; IER = 8'h05;
    push(8'h5A, 3'b010);
    push(8'h11, 3'b000);
    idle(2);
    chk("e_lsr", {24'h0, LSR}, 32'h89);
    chk("e_iir_rls", {24'h0, IIR}, 32'hC6);
    pop();
    idle(2);
    chk("e_iir_rda", {24'h0, IIR}, 32'hC4);
    chk("e_lsr_clean", {24'h0, LSR}, 32'h01);
    pop();
    idle(2);
    chk("e_iir_none", {24'h0, IIR}, 32'hC1);

    // Character timeout with trigger 14
    @(negedge clk);
    FCR = 8'hC1; IER = 8'h01;
    push(8'h77, 3'b000);
    idle(TO_CYCLES - 20);
    chk("t_early", {24'h0, IIR}, 32'hC1);
    idle(30);
    chk("t_cto", {24'h0, IIR}, 32'hCC);
    chk("t_intr", {31'h0, INTR}, 32'h1);
    pop();
    idle(2);
    chk("t_cleared", {24'h0, IIR}, 32'hC1);

    // RX clear discards content and a same-cycle write
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i), 3'b000);
    @(negedge clk);
    FCR = 8'h03; WR = 1'b1; DataIn = 8'h99;
    @(negedge clk);
    WR = 1'b0; FCR = 8'h01;
    sb.delete();
    idle(2);
    chk("clr_level", {27'h0, RxLevel}, 32'h0);
    chk("clr_lsr", {24'h0, LSR}, 32'h00);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push(8'(8'h80 + i), 3'b000);
    idle(1);
    chk("mr_level5", {27'h0, RxLevel}, 32'h5);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_lsr", {24'h0, LSR}, 32'h00);
    chk("mr_iir", {24'h0, IIR}, 32'h01);
    chk("mr_level", {27'h0, RxLevel}, 32'h0);
    chk("mr_dout", {24'h0, DataOut}, 32'h0);
    chk("mr_intr", {31'h0, INTR}, 32'h0);
    sb.delete();
    idle(2);
    reset = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
